// File: rtl/dmem_sram.sv
`default_nettype none
// ============================================================================
// Module   : dmem_sram
// Brief    : Single-port data memory on the load/store req/gnt bus. Handles
//            byte/half/word accesses with sign/zero load extension,
//            programmable wait states and an error response.
// Revision : 1.0  initial release
// ============================================================================
module dmem_sram #(
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] INIT_WORD   = 32'hcaca_caca
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ce_i,
    input  logic        req_i,
    output logic        gnt_o,
    output logic        err_o,
    output logic        busy_o,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    input  logic [1:0]  hb_i,
    input  logic        uload_i,
    output logic [31:0] rdata_o
);

    localparam int unsigned IDXW   = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  c_wait = WAIT_CYCLES[3:0];

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_BUSY = 3'b010,
        S_RESP = 3'b100
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        w_accept, w_commit;

    // Request captured at acceptance so the requester may change its payload
    logic [31:0] addr_q, wdata_q;
    logic        we_q, uload_q;
    logic [1:0]  hb_q;
    logic        err_q;

    // Raw RAM read word plus the formatting of the load that produced it
    logic [31:0] ram_rdata_q;
    logic        ld_valid_q, ld_uload_q;
    logic [1:0]  ld_hb_q, ld_lane_q;

    logic [31:0] mem_q [DEPTH_WORDS] = '{default: INIT_WORD};

    logic [29:0]     w_off;
    logic [IDXW-1:0] w_idx;
    logic            w_err;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_ext;

    // Next-state logic: accept in IDLE, count down in BUSY, one RESP cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_accept = 1'b0;
        w_commit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i && ce_i) begin
                    w_accept = 1'b1;
                    cnt_d    = c_wait;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    w_commit = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, wait counter and captured request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            hb_q    <= 2'b00;
            uload_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                we_q    <= we_i;
                hb_q    <= hb_i;
                uload_q <= uload_i;
            end
            if (w_commit) begin
                err_q <= w_err;
            end
        end
    end

    // Address decode and error classification; word offset avoids the low bits
    always_comb begin
        w_off = addr_q[31:2] - BASE_ADDR[31:2];
        w_idx = w_off[IDXW-1:0];
        w_err = (addr_q < BASE_ADDR)
              | (w_off[29:IDXW] != '0)
              | (hb_q == 2'b11)
              | ((hb_q == 2'b10) && (addr_q[1:0] != 2'b00))
              | ((hb_q == 2'b01) && addr_q[0]);
    end

    // Lane enables and replicated store data so any lane sees its bytes
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = wdata_q;
        case (hb_q)
            2'b00: begin
                w_be    = 4'b0001 << addr_q[1:0];
                w_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                w_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata_q[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Block RAM port: byte-enabled write or synchronous read on the commit edge
    always_ff @(posedge clk_i) begin
        if (w_commit && !w_err) begin
            if (we_q) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        mem_q[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                    end
                end
            end else begin
                ram_rdata_q <= mem_q[w_idx];
            end
        end
    end

    // Remember how the last successful load must be formatted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_valid_q <= 1'b0;
            ld_hb_q    <= 2'b10;
            ld_lane_q  <= 2'b00;
            ld_uload_q <= 1'b0;
        end else if (w_commit && !w_err && !we_q) begin
            ld_valid_q <= 1'b1;
            ld_hb_q    <= hb_q;
            ld_lane_q  <= addr_q[1:0];
            ld_uload_q <= uload_q;
        end
    end

    // Lane select and sign/zero extension of the held read word
    always_comb begin
        case (ld_lane_q)
            2'b00:   w_byte = ram_rdata_q[7:0];
            2'b01:   w_byte = ram_rdata_q[15:8];
            2'b10:   w_byte = ram_rdata_q[23:16];
            default: w_byte = ram_rdata_q[31:24];
        endcase
        w_half = ld_lane_q[1] ? ram_rdata_q[31:16] : ram_rdata_q[15:0];
        case (ld_hb_q)
            2'b00:   w_ext = {{24{~ld_uload_q & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{~ld_uload_q & w_half[15]}}, w_half};
            default: w_ext = ram_rdata_q;
        endcase
    end

    assign gnt_o   = (state_q == S_RESP);
    assign err_o   = (state_q == S_RESP) & err_q;
    assign busy_o  = (state_q != S_IDLE);
    assign rdata_o = ld_valid_q ? w_ext : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_sram.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_sram
// Brief    : Directed self-checking bench for dmem_sram; one instance with no
//            wait states, one with three wait states.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_sram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, ce0, ce3, we, uload;
    logic [1:0]  hb;
    logic [31:0] addr, wdata;
    logic        gnt0, err0, busy0, gnt3, err3, busy3;
    logic [31:0] rdata0, rdata3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_sram #(
        .DEPTH_WORDS (64),
        .BASE_ADDR   (32'h0000_1000),
        .WAIT_CYCLES (0),
        .INIT_WORD   (32'hcaca_caca)
    ) dut0 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .ce_i    (ce0),
        .req_i   (req),
        .gnt_o   (gnt0),
        .err_o   (err0),
        .busy_o  (busy0),
        .addr_i  (addr),
        .wdata_i (wdata),
        .we_i    (we),
        .hb_i    (hb),
        .uload_i (uload),
        .rdata_o (rdata0)
    );

    dmem_sram #(
        .DEPTH_WORDS (64),
        .BASE_ADDR   (32'h0000_1000),
        .WAIT_CYCLES (3),
        .INIT_WORD   (32'hcaca_caca)
    ) dut3 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .ce_i    (ce3),
        .req_i   (req),
        .gnt_o   (gnt3),
        .err_o   (err3),
        .busy_o  (busy3),
        .addr_i  (addr),
        .wdata_i (wdata),
        .we_i    (we),
        .hb_i    (hb),
        .uload_i (uload),
        .rdata_o (rdata3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access; payload is scrambled right after acceptance
    task automatic acc(input bit sel3, input logic w, input logic [1:0] h,
                       input logic [31:0] a, input logic [31:0] d, input logic u,
                       input logic exp_err, input logic [31:0] exp_rd, input string tag);
        int lat;
        lat = sel3 ? 5 : 2;
        @(negedge clk);
        we = w; hb = h; addr = a; wdata = d; uload = u;
        req = 1'b1; ce0 = !sel3; ce3 = sel3;
        @(posedge clk);
        #1;
        req = 1'b0; ce0 = 1'b0; ce3 = 1'b0;
        addr = 32'hFFFF_FFFF; wdata = ~d; we = ~w; hb = ~h; uload = ~u;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            chk({tag, "_gnt_early"}, {31'd0, sel3 ? gnt3 : gnt0}, 32'd0);
        end
        @(negedge clk);
        chk({tag, "_gnt"},   {31'd0, sel3 ? gnt3 : gnt0}, 32'd1);
        chk({tag, "_err"},   {31'd0, sel3 ? err3 : err0}, {31'd0, exp_err});
        chk({tag, "_rdata"}, sel3 ? rdata3 : rdata0, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; ce0 = 1'b0; ce3 = 1'b0;
        we = 1'b0; uload = 1'b0; hb = 2'b10; addr = 32'd0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_gnt0",  {31'd0, gnt0},  32'd0);
        chk("rst_busy0", {31'd0, busy0}, 32'd0);
        chk("rst_err0",  {31'd0, err0},  32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_busy3", {31'd0, busy3}, 32'd0);
        chk("rst_rdata3", rdata3, 32'd0);
        rst_n = 1'b1;

        // Word store/load, no wait states
        acc(0, 1, 2'b10, 32'h1010, 32'h8765_4321, 0, 0, 32'h0000_0000, "st_w");
        acc(0, 0, 2'b10, 32'h1010, 32'h0,         0, 0, 32'h8765_4321, "ld_w");
        // Sub-word extension
        acc(0, 0, 2'b00, 32'h1013, 32'h0, 0, 0, 32'hFFFF_FF87, "ld_b_s");
        acc(0, 0, 2'b00, 32'h1013, 32'h0, 1, 0, 32'h0000_0087, "ld_b_u");
        acc(0, 0, 2'b01, 32'h1012, 32'h0, 0, 0, 32'hFFFF_8765, "ld_h_s");
        acc(0, 0, 2'b01, 32'h1010, 32'h0, 1, 0, 32'h0000_4321, "ld_h_u");
        // Partial stores keep other lanes; rdata unchanged by stores
        acc(0, 1, 2'b00, 32'h1011, 32'h1234_56AA, 0, 0, 32'h0000_4321, "st_b");
        acc(0, 0, 2'b10, 32'h1010, 32'h0,         0, 0, 32'h8765_AA21, "ld_w2");
        acc(0, 1, 2'b01, 32'h1012, 32'hFFFF_1234, 0, 0, 32'h8765_AA21, "st_h");
        acc(0, 0, 2'b10, 32'h1010, 32'h0,         0, 0, 32'h1234_AA21, "ld_w3");
        // Error responses: rdata held, memory untouched
        acc(0, 1, 2'b10, 32'h1002, 32'hDEAD_BEEF, 0, 1, 32'h1234_AA21, "err_misw");
        acc(0, 0, 2'b11, 32'h1010, 32'h0,         0, 1, 32'h1234_AA21, "err_rsv");
        acc(0, 1, 2'b10, 32'h1100, 32'hDEAD_BEEF, 0, 1, 32'h1234_AA21, "err_hi");
        acc(0, 0, 2'b10, 32'h0FFC, 32'h0,         0, 1, 32'h1234_AA21, "err_lo");
        acc(0, 1, 2'b01, 32'h1011, 32'hDEAD_BEEF, 0, 1, 32'h1234_AA21, "err_mish");
        acc(0, 0, 2'b10, 32'h1010, 32'h0,         0, 0, 32'h1234_AA21, "ld_after_err");
        acc(0, 0, 2'b10, 32'h1000, 32'h0,         0, 0, 32'hCACA_CACA, "ld_w0_init");
        acc(0, 0, 2'b00, 32'h1000, 32'h0,         0, 0, 32'hFFFF_FFCA, "ld_b0_init");
        // Last word in range
        acc(0, 1, 2'b10, 32'h10FC, 32'hA5A5_5A5A, 0, 0, 32'hFFFF_FFCA, "st_top");
        acc(0, 0, 2'b10, 32'h10FC, 32'h0,         0, 0, 32'hA5A5_5A5A, "ld_top");

        // Three wait states with req held high: accept at cycle 0 and 6
        @(negedge clk);
        we = 1'b1; hb = 2'b10; addr = 32'h1020; wdata = 32'h1122_3344; uload = 1'b0;
        req = 1'b1; ce3 = 1'b1; ce0 = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("w3_busy_c%0d", k), {31'd0, busy3}, {31'd0, (k != 6)});
            chk($sformatf("w3_gnt_c%0d", k),  {31'd0, gnt3},  {31'd0, (k == 5)});
            chk($sformatf("ce_low_gnt0_c%0d", k), {31'd0, gnt0}, 32'd0);
            if (k == 5) chk("w3_err", {31'd0, err3}, 32'd0);
        end
        req = 1'b0; ce3 = 1'b0;
        for (int k = 8; k <= 11; k++) begin
            @(negedge clk);
            chk($sformatf("w3_gnt2_c%0d", k), {31'd0, gnt3}, {31'd0, (k == 11)});
        end
        acc(1, 0, 2'b10, 32'h1020, 32'h0, 0, 0, 32'h1122_3344, "w3_ld");

        // Reset in the middle of a pending store aborts it
        @(negedge clk);
        we = 1'b1; hb = 2'b10; addr = 32'h1020; wdata = 32'h5566_7788; uload = 1'b0;
        req = 1'b1; ce3 = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0; ce3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", {31'd0, busy3}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_gnt",   {31'd0, gnt3},  32'd0);
        chk("abort_err",   {31'd0, err3},  32'd0);
        chk("abort_busy",  {31'd0, busy3}, 32'd0);
        chk("abort_rdata", rdata3, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort_nognt_%0d", k), {31'd0, gnt3}, 32'd0);
        end
        rst_n = 1'b1;
        acc(1, 0, 2'b10, 32'h1020, 32'h0, 0, 0, 32'h1122_3344, "abort_ld");
        acc(1, 0, 2'b10, 32'h1024, 32'h0, 0, 0, 32'hCACA_CACA, "w3_ld_init");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
